// File: rtl/store_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer_if
//  Purpose  : Bundles the commit-side store handshake, the LSU load/forwarding
//             lookup and the memory-controller write channel of the store
//             write buffer into one interface.
//  Modports : master - commit unit / LSU / memory controller side
//             slave  - store_write_buffer side
//  Signals  : write_mem_req, store_addr, store_data, write_mem_req_granted
//             load_req, load_addr, fwd_hit, fwd_data
//             mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_ack
//             buf_full, buf_empty
//  Revision : 1.0 - initial release
// ============================================================================
interface store_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              write_mem_req;
  logic [ADDR_W-1:0] store_addr;
  logic [DATA_W-1:0] store_data;
  logic              write_mem_req_granted;
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ack;
  logic              buf_full;
  logic              buf_empty;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output write_mem_req, store_addr, store_data, load_req, load_addr, mem_wr_ack,
    input  write_mem_req_granted, mem_wr_req, mem_wr_addr, mem_wr_data,
           buf_full, buf_empty, fwd_hit, fwd_data
  );

  modport slave (
    input  write_mem_req, store_addr, store_data, load_req, load_addr, mem_wr_ack,
    output write_mem_req_granted, mem_wr_req, mem_wr_addr, mem_wr_data,
           buf_full, buf_empty, fwd_hit, fwd_data
  );
endinterface
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_write_buffer
//  Purpose  : Memory-side responder for committed stores. Accepts store
//             address/data into a DEPTH-entry FIFO, grants each store with a
//             registered one-cycle pulse, and drains the FIFO in strict order
//             to the memory controller over a req/ack handshake. Loads own the
//             memory port unless the buffer is full.
//  Ports    : clk_i  - system clock
//             rst_ni - asynchronous active-low reset
//             bus    - store_write_buffer_if.slave (commit, LSU, memory side)
//  Options  : STORE_FWD_EN - when defined, builds store-to-load forwarding
//             (fwd_hit/fwd_data from the youngest matching buffered entry);
//             otherwise fwd_hit/fwd_data are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  store_write_buffer_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  localparam logic [PTR_W:0] c_FULL_CNT = (PTR_W+1)'(DEPTH);

  state_e            state_q,  state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic              grant_q,  grant_d;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic              full;
  logic              empty;
  logic              enq;
  logic              deq;

  assign full  = (count_q == c_FULL_CNT);
  assign empty = (count_q == '0);

  // A request seen while the grant pulse is high belongs to the store just
  // granted (commit drops req in reaction to the grant), so it is ignored.
  assign enq = bus.write_mem_req & ~full & ~grant_q;
  assign deq = (state_q == ISSUE) & bus.mem_wr_ack;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    grant_d  = enq;

    unique case (state_q)
      IDLE: begin
        // Loads win the port unless the buffer is full and would stall commit.
        if (!empty && (!bus.load_req || full)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Once issued the request is held until ack, regardless of load_req.
        if (bus.mem_wr_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
    end
  end

  // Entry storage needs no reset: validity is defined by rd_ptr/count only.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= bus.store_addr;
      data_mem_q[wr_ptr_q] <= bus.store_data;
    end
  end

  assign bus.write_mem_req_granted = grant_q;
  assign bus.mem_wr_req            = (state_q == ISSUE);
  assign bus.mem_wr_addr           = addr_mem_q[rd_ptr_q];
  assign bus.mem_wr_data           = data_mem_q[rd_ptr_q];
  assign bus.buf_full              = full;
  assign bus.buf_empty             = empty;

  // Byte-offset bits never take part in the word-address match.
  logic unused_load_addr;
  assign unused_load_addr = ^bus.load_addr;

`ifdef STORE_FWD_EN
  // Walk valid entries oldest to youngest; a later match overrides an earlier
  // one, so the result is the youngest matching store.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PTR_W+1)'(k) < count_q) &&
          (addr_mem_q[rd_ptr_q + PTR_W'(k)][ADDR_W-1:2] == bus.load_addr[ADDR_W-1:2])) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = data_mem_q[rd_ptr_q + PTR_W'(k)];
      end
    end
  end
`else
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_write_buffer
//  Purpose  : Self-checking bench for store_write_buffer: directed vector
//             table, directed multi-cycle sequences, and randomized traffic
//             compared against a queue-based reference model.
//  Options  : STORE_FWD_EN - must match the DUT build; selects the expected
//             forwarding behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_store_write_buffer;

`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  store_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_write_buffer #(
    .DEPTH (DEPTH),
    .PTR_W (2),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected DUT event within bound", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_mem_req = 1'b0;
    bus.store_addr    = '0;
    bus.store_data    = '0;
    bus.load_req      = 1'b0;
    bus.load_addr     = '0;
    bus.mem_wr_ack    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  // Commit-side store: hold req until granted, report cycles waited.
  task automatic store(input logic [31:0] a, input logic [31:0] d, output int waited);
    bus.write_mem_req = 1'b1;
    bus.store_addr    = a;
    bus.store_data    = d;
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.write_mem_req_granted) begin
        waited = i + 1;
        break;
      end
    end
    bus.write_mem_req = 1'b0;
    if (waited < 0) timeout("store_grant");
  endtask

  // Memory-side: wait for a write request, check it, ack it for one cycle.
  task automatic drain_expect(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 20 && !bus.mem_wr_req; i++) cyc();
    if (!bus.mem_wr_req) begin
      timeout("drain_req");
    end else begin
      chk("drain_addr", bus.mem_wr_addr, a);
      chk("drain_data", bus.mem_wr_data, d);
      bus.mem_wr_ack = 1'b1;
      cyc();
      bus.mem_wr_ack = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
  endfunction

  // ------------------------------------------------------ reference model
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_grant;
  bit   m_issue;

  task automatic run_model(input int n, input bit heavy);
    bit          full, enq, deq, n_issue, e_hit;
    logic [31:0] e_fwd;
    mq.delete();
    m_grant = 1'b0;
    m_issue = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (bus.write_mem_req && bus.write_mem_req_granted) bus.write_mem_req = 1'b0;
      if (!bus.write_mem_req && (heavy || $urandom_range(0, 2) == 0)) begin
        bus.write_mem_req = 1'b1;
        bus.store_addr    = rnd_addr();
        bus.store_data    = $urandom;
      end
      bus.load_req   = heavy ? 1'b0 : ($urandom_range(0, 2) == 0);
      bus.load_addr  = rnd_addr();
      bus.mem_wr_ack = heavy ? 1'b1 : ($urandom_range(0, 1) == 1);
      #1;
      chk("m_grant", bus.write_mem_req_granted, m_grant);
      chk("m_wr_req", bus.mem_wr_req, m_issue);
      if (m_issue) begin
        chk("m_wr_addr", bus.mem_wr_addr, mq[0].a);
        chk("m_wr_data", bus.mem_wr_data, mq[0].d);
      end
      chk("m_full", bus.buf_full, mq.size() == DEPTH);
      chk("m_empty", bus.buf_empty, mq.size() == 0);
      e_hit = 1'b0;
      e_fwd = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (FWD && mq[i].a[31:2] == bus.load_addr[31:2]) begin
          e_hit = 1'b1;
          e_fwd = mq[i].d;
          break;
        end
      end
      chk("m_fwd_hit", bus.fwd_hit, e_hit);
      chk("m_fwd_data", bus.fwd_data, e_fwd);

      @(posedge clk);
      full    = (mq.size() == DEPTH);
      enq     = bus.write_mem_req && !full && !m_grant;
      deq     = m_issue && bus.mem_wr_ack;
      n_issue = m_issue ? !bus.mem_wr_ack
                        : (mq.size() != 0 && (!bus.load_req || full));
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back('{a: bus.store_addr, d: bus.store_data});
      m_grant = enq;
      m_issue = n_issue;
      #1;
    end
    bus.write_mem_req = 1'b0;
    bus.mem_wr_ack    = 1'b0;
    bus.load_req      = 1'b0;
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    bit          req;
    logic [31:0] addr;
    logic [31:0] data;
    bit          load;
    bit          ack;
    bit          e_grant;
    bit          e_req;
    bit          e_empty;
    bit          e_full;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[6];

  initial begin
    int w;

    vt[0] = '{1, 32'h100, 32'hDEADBEEF, 0, 0,  0, 0, 1, 0, 32'h0,   32'h0};
    vt[1] = '{0, 32'h100, 32'hDEADBEEF, 0, 0,  1, 0, 0, 0, 32'h0,   32'h0};
    vt[2] = '{0, 32'h0,   32'h0,        0, 0,  0, 1, 0, 0, 32'h100, 32'hDEADBEEF};
    vt[3] = '{0, 32'h0,   32'h0,        0, 0,  0, 1, 0, 0, 32'h100, 32'hDEADBEEF};
    vt[4] = '{0, 32'h0,   32'h0,        0, 1,  0, 1, 0, 0, 32'h100, 32'hDEADBEEF};
    vt[5] = '{0, 32'h0,   32'h0,        0, 0,  0, 0, 1, 0, 32'h0,   32'h0};

    // Reset state
    do_reset();
    chk("rst_grant", bus.write_mem_req_granted, 0);
    chk("rst_wr_req", bus.mem_wr_req, 0);
    chk("rst_fwd_hit", bus.fwd_hit, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    chk("rst_empty", bus.buf_empty, 1);
    chk("rst_full", bus.buf_full, 0);

    // Single store: grant timing and write handshake
    for (int i = 0; i < 6; i++) begin
      bus.write_mem_req = vt[i].req;
      bus.store_addr    = vt[i].addr;
      bus.store_data    = vt[i].data;
      bus.load_req      = vt[i].load;
      bus.mem_wr_ack    = vt[i].ack;
      #1;
      chk($sformatf("vec%0d_grant", i), bus.write_mem_req_granted, vt[i].e_grant);
      chk($sformatf("vec%0d_wr_req", i), bus.mem_wr_req, vt[i].e_req);
      chk($sformatf("vec%0d_empty", i), bus.buf_empty, vt[i].e_empty);
      chk($sformatf("vec%0d_full", i), bus.buf_full, vt[i].e_full);
      if (vt[i].e_req) begin
        chk($sformatf("vec%0d_addr", i), bus.mem_wr_addr, vt[i].e_addr);
        chk($sformatf("vec%0d_data", i), bus.mem_wr_data, vt[i].e_data);
      end
      @(posedge clk);
      #1;
    end

    // Full buffer: 5th store waits for the first ack
    do_reset();
    store(32'h10, 32'hA000_0010, w);
    chk("full_first_latency", w, 1);
    store(32'h14, 32'hA000_0014, w);
    store(32'h18, 32'hA000_0018, w);
    store(32'h1C, 32'hA000_001C, w);
    chk("full_flag", bus.buf_full, 1);
    chk("full_wr_req", bus.mem_wr_req, 1);
    bus.write_mem_req = 1'b1;
    bus.store_addr    = 32'h20;
    bus.store_data    = 32'hA000_0020;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_no_grant", bus.write_mem_req_granted, 0);
    end
    drain_expect(32'h10, 32'hA000_0010);
    chk("full_grant_after_ack", bus.write_mem_req_granted, 0);
    chk("full_cleared", bus.buf_full, 0);
    cyc();
    chk("full_5th_granted", bus.write_mem_req_granted, 1);
    bus.write_mem_req = 1'b0;
    drain_expect(32'h14, 32'hA000_0014);
    drain_expect(32'h18, 32'hA000_0018);
    drain_expect(32'h1C, 32'hA000_001C);
    drain_expect(32'h20, 32'hA000_0020);
    chk("full_drained_empty", bus.buf_empty, 1);

    // Load priority
    do_reset();
    bus.load_req = 1'b1;
    store(32'h40, 32'hB40, w);
    store(32'h44, 32'hB44, w);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("load_prio_hold", bus.mem_wr_req, 0);
    end
    store(32'h48, 32'hB48, w);
    store(32'h4C, 32'hB4C, w);
    chk("load_prio_full", bus.buf_full, 1);
    cyc();
    chk("load_prio_full_issue", bus.mem_wr_req, 1);
    drain_expect(32'h40, 32'hB40);
    cyc();
    cyc();
    chk("load_prio_after_free", bus.mem_wr_req, 0);
    bus.load_req = 1'b0;
    drain_expect(32'h44, 32'hB44);
    drain_expect(32'h48, 32'hB48);
    drain_expect(32'h4C, 32'hB4C);
    chk("load_prio_empty", bus.buf_empty, 1);

    // Wrap with back-to-back stores and ack always high
    do_reset();
    run_model(40, 1'b1);

    // Randomized traffic
    do_reset();
    run_model(400, 1'b0);

    // Async reset in the middle of a write request
    do_reset();
    store(32'h80, 32'hC80, w);
    store(32'h84, 32'hC84, w);
    store(32'h88, 32'hC88, w);
    chk("areset_pre_req", bus.mem_wr_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_wr_req", bus.mem_wr_req, 0);
    chk("areset_empty", bus.buf_empty, 1);
    chk("areset_grant", bus.write_mem_req_granted, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("areset_post_grant", bus.write_mem_req_granted, 0);
      chk("areset_post_wr_req", bus.mem_wr_req, 0);
      chk("areset_post_empty", bus.buf_empty, 1);
    end

    // Forwarding: youngest match wins, same-cycle enqueue invisible
    do_reset();
    bus.load_req = 1'b1;
    store(32'h200, 32'h1, w);
    store(32'h200, 32'h2, w);
    bus.load_addr = 32'h200;
    #1;
    chk("fwd_hit", bus.fwd_hit, FWD);
    chk("fwd_data", bus.fwd_data, FWD ? 32'h2 : 32'h0);
    bus.load_addr = 32'h203;
    #1;
    chk("fwd_same_word", bus.fwd_hit, FWD);
    bus.load_addr = 32'h204;
    #1;
    chk("fwd_miss", bus.fwd_hit, 0);
    cyc();
    bus.write_mem_req = 1'b1;
    bus.store_addr    = 32'h300;
    bus.store_data    = 32'h7;
    bus.load_addr     = 32'h300;
    #1;
    chk("fwd_same_cycle_hidden", bus.fwd_hit, 0);
    cyc();
    bus.write_mem_req = 1'b0;
    chk("fwd_enq_grant", bus.write_mem_req_granted, 1);
    chk("fwd_next_cycle_hit", bus.fwd_hit, FWD);
    chk("fwd_next_cycle_data", bus.fwd_data, FWD ? 32'h7 : 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
